// File: rtl/mem_access_arbiter_if.sv
// Bus between the core array, the round-robin memory arbiter and the shared single-port RAM.
// Core-side request/ack signals and RAM-side signals are grouped so one instance wires the whole block.
interface mem_access_arbiter_if #(
    parameter int CORE_COUNT = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic [CORE_COUNT-1:0]            reqIn;
    logic [CORE_COUNT-1:0]            wrEnIn;
    logic [CORE_COUNT*ADDR_WIDTH-1:0] addrIn;
    logic [CORE_COUNT*DATA_WIDTH-1:0] dataIn;
    logic [CORE_COUNT-1:0]            grant;
    logic [CORE_COUNT-1:0]            ack;
    logic [DATA_WIDTH-1:0]            dataOut;
    logic                             busy;
    logic [ADDR_WIDTH-1:0]            memAddr;
    logic [DATA_WIDTH-1:0]            memWrData;
    logic                             memWrEn;
    logic [DATA_WIDTH-1:0]            memRdData;

    modport slave (
        input  reqIn, wrEnIn, addrIn, dataIn, memRdData,
        output grant, ack, dataOut, busy, memAddr, memWrData, memWrEn
    );

    modport master (
        output reqIn, wrEnIn, addrIn, dataIn, memRdData,
        input  grant, ack, dataOut, busy, memAddr, memWrData, memWrEn
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter sharing one single-port RAM (1-cycle registered read) among CORE_COUNT cores.
// Each transaction runs IDLE -> ISSUE -> CAPTURE -> ACK and completes with a 4-phase req/ack handshake.
module mem_access_arbiter #(
    parameter int CORE_COUNT = 4,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rstN,
    mem_access_arbiter_if.slave bus
);
    localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_ACK     = 2'd3;

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(CORE_COUNT - 1);
    localparam logic [CORE_COUNT-1:0] ONE_HOT0 = {{(CORE_COUNT-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_rr_ptr;
    logic [IDX_W-1:0]      r_win;
    logic                  r_wr_op;
    logic [CORE_COUNT-1:0] r_grant;
    logic [CORE_COUNT-1:0] r_ack;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_busy;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  r_mem_wr_en;

    logic                  w_found;
    logic [IDX_W-1:0]      w_pick;
    logic [IDX_W-1:0]      w_next_ptr;

    // Returns {found, index}; scanning from the farthest offset down lets the nearest requester to ptr win.
    function automatic logic [IDX_W:0] rr_pick(input logic [CORE_COUNT-1:0] req,
                                               input logic [IDX_W-1:0]      ptr);
        logic [IDX_W:0]   result;
        logic [IDX_W-1:0] idx_v;
        result = {(IDX_W+1){1'b0}};
        for (int k = CORE_COUNT - 1; k >= 0; k--) begin
            idx_v = IDX_W'((int'(ptr) + k) % CORE_COUNT);
            if (req[idx_v]) begin
                result = {1'b1, idx_v};
            end
        end
        return result;
    endfunction

    // Winner selection and the pointer value to load when the current transaction retires.
    always_comb begin
        {w_found, w_pick} = rr_pick(bus.reqIn, r_rr_ptr);
        w_next_ptr = (r_win == LAST_IDX) ? {IDX_W{1'b0}} : (r_win + IDX_W'(1));
    end

    // Transaction FSM with all outputs held in registers.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= {IDX_W{1'b0}};
            r_win         <= {IDX_W{1'b0}};
            r_wr_op       <= 1'b0;
            r_grant       <= {CORE_COUNT{1'b0}};
            r_ack         <= {CORE_COUNT{1'b0}};
            r_data_out    <= {DATA_WIDTH{1'b0}};
            r_busy        <= 1'b0;
            r_mem_addr    <= {ADDR_WIDTH{1'b0}};
            r_mem_wr_data <= {DATA_WIDTH{1'b0}};
            r_mem_wr_en   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state       <= S_ISSUE;
                        r_win         <= w_pick;
                        r_wr_op       <= bus.wrEnIn[w_pick];
                        r_mem_wr_en   <= bus.wrEnIn[w_pick];
                        r_mem_addr    <= bus.addrIn[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
                        r_mem_wr_data <= bus.dataIn[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
                        r_grant       <= ONE_HOT0 << w_pick;
                        r_busy        <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_state     <= S_CAPTURE;
                    r_mem_wr_en <= 1'b0;
                end
                S_CAPTURE: begin
                    // RAM data for the address presented in ISSUE is valid during this cycle.
                    r_state <= S_ACK;
                    r_ack   <= r_grant;
                    if (!r_wr_op) begin
                        r_data_out <= bus.memRdData;
                    end
                end
                S_ACK: begin
                    if (!bus.reqIn[r_win]) begin
                        r_state  <= S_IDLE;
                        r_ack    <= {CORE_COUNT{1'b0}};
                        r_grant  <= {CORE_COUNT{1'b0}};
                        r_busy   <= 1'b0;
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ack       <= {CORE_COUNT{1'b0}};
                    r_grant     <= {CORE_COUNT{1'b0}};
                    r_busy      <= 1'b0;
                    r_mem_wr_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.ack       = r_ack;
    assign bus.dataOut   = r_data_out;
    assign bus.busy      = r_busy;
    assign bus.memAddr   = r_mem_addr;
    assign bus.memWrData = r_mem_wr_data;
    assign bus.memWrEn   = r_mem_wr_en;
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-level model (round-robin pick from pointer, sparse memory image, expected dataOut).
module tb_mem_access_arbiter;
    localparam int N  = 4;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    mem_access_arbiter_if #(.CORE_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    mem_access_arbiter #(.CORE_COUNT(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (ifc)
    );

    // RAM environment: registered read, write on strobe, unwritten words follow a fixed pattern.
    logic [DW-1:0] ram     [0:(1<<AW)-1];
    bit            ram_vld [0:(1<<AW)-1];
    logic          pre_en   = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a * 37 + 21);
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_addr]     <= pre_data;
            ram_vld[pre_addr] <= 1'b1;
        end else if (ifc.memWrEn) begin
            ram[ifc.memAddr]     <= ifc.memWrData;
            ram_vld[ifc.memAddr] <= 1'b1;
        end
        ifc.memRdData <= ram_vld[ifc.memAddr] ? ram[ifc.memAddr] : init_word(int'(ifc.memAddr));
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [int];
    int            ref_ptr;
    logic [DW-1:0] ref_dout;

    // Per-core stimulus.
    logic [N-1:0]  req_v  = '0;
    logic [N-1:0]  wr_v   = '0;
    logic [AW-1:0] addr_v [N];
    logic [DW-1:0] data_v [N];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [DW-1:0] ref_rd(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic int model_pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[IW'((ptr + k) % N)]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v = '0;
        v[IW'(i)] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ifc.reqIn  = req_v;
        ifc.wrEnIn = wr_v;
        for (int k = 0; k < N; k++) begin
            ifc.addrIn[k*AW +: AW] = addr_v[k];
            ifc.dataIn[k*DW +: DW] = data_v[k];
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_v[IW'(k)] = wr;
        addr_v[k]    = a;
        data_v[k]    = d;
        req_v[IW'(k)] = 1'b1;
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        #1;
        chk("rst_grant", 32'(ifc.grant), 32'(0));
        chk("rst_ack", 32'(ifc.ack), 32'(0));
        chk("rst_dout", 32'(ifc.dataOut), 32'(0));
        chk("rst_busy", 32'(ifc.busy), 32'(0));
        chk("rst_addr", 32'(ifc.memAddr), 32'(0));
        chk("rst_wdata", 32'(ifc.memWrData), 32'(0));
        chk("rst_we", 32'(ifc.memWrEn), 32'(0));
        ref_ptr  = 0;
        ref_dout = '0;
        step();
        step();
        rstN = 1'b1;
    endtask

    // One arbitration round starting from an idle sample point; exp_win < 0 lets the model decide.
    task automatic serve(input int exp_win, input int hold, input bit early, input bit scramble);
        int            w;
        logic          t_wr;
        logic [AW-1:0] t_addr;
        logic [DW-1:0] t_data;
        w      = (exp_win >= 0) ? exp_win : model_pick(req_v, ref_ptr);
        t_wr   = wr_v[IW'(w)];
        t_addr = addr_v[w];
        t_data = data_v[w];
        chk("pre_busy", 32'(ifc.busy), 32'(0));
        step();
        chk("iss_grant", 32'(ifc.grant), 32'(oh(w)));
        chk("iss_ack", 32'(ifc.ack), 32'(0));
        chk("iss_busy", 32'(ifc.busy), 32'(1));
        chk("iss_we", 32'(ifc.memWrEn), 32'(t_wr));
        chk("iss_addr", 32'(ifc.memAddr), 32'(t_addr));
        chk("iss_wdata", 32'(ifc.memWrData), 32'(t_data));
        if (early) req_v[IW'(w)] = 1'b0;
        if (scramble) begin
            for (int k = 0; k < N; k++) begin
                if (k != w) req_v[IW'(k)] = 1'($urandom_range(0, 1));
                wr_v[IW'(k)] = 1'($urandom_range(0, 1));
                addr_v[k]    = AW'($urandom_range(0, 31));
                data_v[k]    = DW'($urandom);
            end
        end
        step();
        chk("cap_we", 32'(ifc.memWrEn), 32'(0));
        chk("cap_addr", 32'(ifc.memAddr), 32'(t_addr));
        chk("cap_ack", 32'(ifc.ack), 32'(0));
        chk("cap_grant", 32'(ifc.grant), 32'(oh(w)));
        step();
        if (t_wr) ref_mem[int'(t_addr)] = t_data;
        else      ref_dout = ref_rd(int'(t_addr));
        chk("ack_onehot", 32'(ifc.ack), 32'(oh(w)));
        chk("ack_grant", 32'(ifc.grant), 32'(oh(w)));
        chk("ack_dout", 32'(ifc.dataOut), 32'(ref_dout));
        chk("ack_we", 32'(ifc.memWrEn), 32'(0));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                step();
                chk("ack_hold", 32'(ifc.ack), 32'(oh(w)));
            end
            req_v[IW'(w)] = 1'b0;
        end
        step();
        chk("end_ack", 32'(ifc.ack), 32'(0));
        chk("end_grant", 32'(ifc.grant), 32'(0));
        chk("end_busy", 32'(ifc.busy), 32'(0));
        chk("end_we", 32'(ifc.memWrEn), 32'(0));
        ref_ptr = (w + 1) % N;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            addr_v[k] = '0;
            data_v[k] = '0;
        end
        do_reset();

        // Single read of a preloaded word by core1.
        pre_en = 1'b1; pre_addr = 12'h010; pre_data = 12'h5A5;
        step();
        pre_en = 1'b0;
        ref_mem[16] = 12'h5A5;
        set_core(1, 1'b0, 12'h010, 12'h000);
        serve(1, 0, 1'b0, 1'b0);
        chk("t1_dout", 32'(ifc.dataOut), 32'(12'h5A5));

        // Core2 writes, then core0 reads the same word back.
        set_core(2, 1'b1, 12'h020, 12'hABC);
        serve(2, 1, 1'b0, 1'b0);
        chk("t2_dout_kept", 32'(ifc.dataOut), 32'(12'h5A5));
        set_core(0, 1'b0, 12'h020, 12'h000);
        serve(0, 0, 1'b0, 1'b0);
        chk("t2_readback", 32'(ifc.dataOut), 32'(12'hABC));

        // Fairness: all four cores requesting straight out of reset.
        for (int k = 0; k < N; k++) set_core(k, 1'b0, AW'(k + 1), 12'h000);
        do_reset();
        for (int k = 0; k < N; k++) serve(k, k % 2, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) set_core(k, 1'b0, AW'(k + 8), 12'h000);
        serve(0, 0, 1'b0, 1'b0);
        for (int k = 1; k < N; k++) serve(k, 0, 1'b0, 1'b0);

        // Pointer wrap: after core2, pointer sits at 3 and beats core0.
        req_v = '0;
        do_reset();
        set_core(2, 1'b0, 12'h005, 12'h000);
        serve(2, 0, 1'b0, 1'b0);
        set_core(0, 1'b0, 12'h006, 12'h000);
        set_core(3, 1'b0, 12'h007, 12'h000);
        serve(3, 0, 1'b0, 1'b0);
        serve(0, 0, 1'b0, 1'b0);

        // Early drop: one-cycle request still completes with a one-cycle ack.
        set_core(0, 1'b0, 12'h020, 12'h000);
        serve(0, 0, 1'b1, 1'b0);
        step();
        chk("t5_stay_idle", 32'(ifc.busy), 32'(0));

        // Reset in the middle of a write.
        set_core(1, 1'b0, 12'h001, 12'h000);
        serve(1, 0, 1'b0, 1'b0);
        set_core(2, 1'b1, 12'h030, 12'h123);
        step();
        chk("t6_issue_we", 32'(ifc.memWrEn), 32'(1));
        req_v = '0;
        do_reset();
        set_core(0, 1'b0, 12'h030, 12'h000);
        set_core(3, 1'b0, 12'h031, 12'h000);
        serve(0, 0, 1'b0, 1'b0);
        chk("t6_no_write", 32'(ifc.dataOut), 32'(init_word(12'h030)));
        serve(3, 0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int r = 0; r < 60; r++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_v[IW'(k)] && ($urandom_range(0, 1) == 1)) begin
                    set_core(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
                end
            end
            if (req_v == '0) begin
                step();
                chk("rnd_idle", 32'(ifc.busy), 32'(0));
            end else begin
                serve(-1, int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
